hs_opt_flow_top: RTL and testbench
==================================

Name: hs_opt_flow_top

Overview:
- Streaming Horn-Schunck optical-flow front end.
- Accepts two 8-bit grayscale frames (frame k on data_in1, frame k+1 on data_in2), one co-located pixel pair per clock in raster order.
- Emits one 26-bit signed fixed-point flow value per pixel after a fixed pipeline latency.
- Computes a single Horn-Schunck iteration from zero initial flow. Output component alternates per frame period: u, then v.

Parameters:
- IMAGE_WIDTH, 584, pixels per row.
- IMAGE_HEIGHT, 388, rows per frame.
- FP_WIDTH, 26, output word width, signed Q16.10.
- ALPHA2, 1, regularisation constant alpha^2 (integer, >=1).
- LATENCY, 34, cycles from pixel input to its result on io_data_out.

Ports:
- clk  in  1  single system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high.
- io_frame_sync_in  in  1  one-cycle pulse coincident with pixel (0,0) of a frame pair.
- io_data_in1  in  8  unsigned pixel of frame k.
- io_data_in2  in  8  unsigned pixel of frame k+1.
- io_frame_sync_out  out  1  one-cycle pulse coincident with the result for pixel (0,0).
- io_data_out  out  FP_WIDTH  signed Q16.10 flow component.

Behaviour:
- Reset: io_frame_sync_out=0 and io_data_out=0; pipeline valid bits cleared; column/row counters = 0; component select = u.
- Input handshake: none. Valid data arrives every cycle, IMAGE_WIDTH*IMAGE_HEIGHT pixels per frame, frames back to back.
- Counters: col/row increment every cycle. col wraps at IMAGE_WIDTH-1 and then row increments; row wraps at IMAGE_HEIGHT-1.
- Frame sync: io_frame_sync_in forces col=row=0 for the current pixel, even mid-frame (resynchronise). It also toggles the component select. The first frame after reset is u, the next is v, and so on.
- Line buffers: one IMAGE_WIDTH x 8 buffer per input. Together with last-pixel registers, these form the causal 2x2x2 window A=(r-1,c-1), B=(r-1,c), C=(r,c-1), D=(r,c) for frames E1 and E2.
- Gradients (integer, 11-bit signed):
  - Gx = (B1-A1)+(D1-C1)+(B2-A2)+(D2-C2)
  - Gy = (C1-A1)+(D1-B1)+(C2-A2)+(D2-B2)
  - Gt = (A2-A1)+(B2-B1)+(C2-C1)+(D2-D1)
- Result:
  - den = 16*ALPHA2 + Gx^2 + Gy^2 (unsigned, 22 bits).
  - num = -(Gsel*Gt)*1024, where Gsel = Gx for u and Gy for v (signed, 32 bits).
  - out = num/den, truncated toward zero, sign-extended into FP_WIDTH bits; it is guaranteed to fit.
- Boundary: when row==0 or col==0 the window is incomplete and the result is exactly 0.
- Timing:
  - The result for input pixel n appears on io_data_out exactly LATENCY cycles after that pixel is presented.
  - io_frame_sync_out is io_frame_sync_in delayed by LATENCY.
  - Throughput is one result per cycle; the divider is fully pipelined (one restoring stage per quotient bit).
- Component select is captured with each pixel and carried down the pipeline. A frame therefore never mixes u and v.
- Reset mid-operation: all in-flight results are discarded. Outputs return to 0 the next cycle, with no spurious sync_out.

Decomposition:
- Shared package: IMAGE_WIDTH, IMAGE_HEIGHT, FP_WIDTH, FRAC_BITS=10, ALPHA2, the gradient width, and the signed Q16.10 fixed-point type.
- One sub-module: hs_pipe_divider, a signed-numerator / unsigned-denominator pipelined divider with a valid/sideband shift (carries the sync and component bits).
- Line buffers, gradients and multipliers stay in the top.

Test Plan:
- Reset held 5 cycles -> io_data_out=0 and io_frame_sync_out=0 throughout. First sync_out occurs exactly LATENCY cycles after the first io_frame_sync_in.
- Both frames constant 100 -> Gx=Gy=Gt=0; every output is 0 for u and v frames.
- Frame1 all 0, frame2 all 8, first (u) frame -> Gt=32, Gx=0, so output 0. Under the same input, a horizontal ramp with data_in1=data_in2=col gives Gx=4 and Gt=0, so output 0.
- Frame1 pixel=col, frame2 pixel=col+1, ALPHA2=1, u frame -> Gx=4, Gy=0, Gt=4, den=32. Interior output = -16*1024/32 = -512 (0x3FFFE00); row 0 and col 0 outputs = 0.
- Same stimulus in the following (v) frame -> Gy=0, so all outputs 0. The third frame returns to u, giving -512 again.
- Pulse io_frame_sync_in mid-frame at pixel 1000 -> counters restart, that pixel's result is boundary 0, and sync_out appears LATENCY cycles later.

Source files
------------

// File: rtl/hs_opt_flow_pkg.sv
// Shared constants and types for the Horn-Schunck optical-flow front end.
// The package holds no logic, so it has no latency and no backpressure.
package hs_opt_flow_pkg;
    localparam int IMAGE_WIDTH  = 584;
    localparam int IMAGE_HEIGHT = 388;
    localparam int FP_WIDTH     = 26;
    localparam int FRAC_BITS    = 10;
    localparam int ALPHA2       = 1;
    localparam int LATENCY      = 34;

    localparam int PIX_W  = 8;
    localparam int GRAD_W = 11;
    localparam int DEN_W  = 22;
    localparam int NUM_W  = 32;
    // The front end has three register stages and the divider adds one output register.
    localparam int DIV_QBITS = LATENCY - 4;

    typedef logic [PIX_W-1:0]           pix_t;
    typedef logic signed [GRAD_W-1:0]   grad_t;
    typedef logic signed [FP_WIDTH-1:0] fp_t;

    typedef enum logic {
        COMP_U = 1'b0,
        COMP_V = 1'b1
    } comp_e;

    typedef struct packed {
        logic  sync;
        comp_e comp;
        logic  bnd;
    } meta_t;

    function automatic grad_t pdiff(input pix_t hi, input pix_t lo);
        return grad_t'({3'b000, hi}) - grad_t'({3'b000, lo});
    endfunction
endpackage

// File: rtl/hs_pipe_divider.sv
// Pipelined divider: signed numerator by unsigned denominator, truncating toward zero, with a valid/sideband shift.
// Latency is QBITS+1 cycles at one result per cycle; there is no backpressure, and invalid slots produce 0.
module hs_pipe_divider #(
    parameter int NUM_W = 32,
    parameter int DEN_W = 22,
    parameter int QBITS = 30,
    parameter int OUT_W = 26,
    parameter int SB_W  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_vld,
    input  logic signed [NUM_W-1:0] in_num,
    input  logic [DEN_W-1:0]        in_den,
    input  logic [SB_W-1:0]         in_sb,
    output logic [OUT_W-1:0]        out_q,
    output logic [SB_W-1:0]         out_sb
);
    logic [QBITS-1:0] mag;
    logic [QBITS-1:0] dvd_i [QBITS];
    logic [DEN_W-1:0] rem_i [QBITS];
    logic [DEN_W-1:0] den_i [QBITS];
    logic [DEN_W:0]   trial [QBITS];
    logic             ge    [QBITS];
    logic [QBITS-1:0] dvd_n [QBITS];
    logic [DEN_W-1:0] rem_n [QBITS];

    logic [QBITS-1:0] dvd_q [QBITS];
    logic [DEN_W-1:0] rem_q [QBITS];
    logic [DEN_W-1:0] den_q [QBITS];
    logic [SB_W-1:0]  sb_q  [QBITS];
    logic [QBITS-1:0] vld_q;
    logic [QBITS-1:0] neg_q;
    logic [QBITS-1:0] quo;

    always_comb begin
        mag = in_num[NUM_W-1] ? QBITS'(-in_num) : QBITS'(in_num);
        dvd_i[0] = mag;
        rem_i[0] = '0;
        den_i[0] = in_den;
        for (int i = 1; i < QBITS; i++) begin
            dvd_i[i] = dvd_q[i-1];
            rem_i[i] = rem_q[i-1];
            den_i[i] = den_q[i-1];
        end
    end

    // Dividend bits leave at the top of dvd while quotient bits enter at the bottom.
    always_comb begin
        for (int i = 0; i < QBITS; i++) begin
            trial[i] = {rem_i[i], dvd_i[i][QBITS-1]};
            ge[i]    = trial[i] >= {1'b0, den_i[i]};
            dvd_n[i] = {dvd_i[i][QBITS-2:0], ge[i]};
            rem_n[i] = ge[i] ? DEN_W'(trial[i] - {1'b0, den_i[i]}) : trial[i][DEN_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < QBITS; i++) begin
            dvd_q[i] <= dvd_n[i];
            rem_q[i] <= rem_n[i];
            den_q[i] <= den_i[i];
        end
        neg_q <= {neg_q[QBITS-2:0], in_num[NUM_W-1]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= '0;
            for (int i = 0; i < QBITS; i++) sb_q[i] <= '0;
        end else begin
            vld_q   <= {vld_q[QBITS-2:0], in_vld};
            sb_q[0] <= in_sb;
            for (int i = 1; i < QBITS; i++) sb_q[i] <= sb_q[i-1];
        end
    end

    assign quo = dvd_q[QBITS-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_q  <= '0;
            out_sb <= '0;
        end else if (vld_q[QBITS-1]) begin
            out_q  <= neg_q[QBITS-1] ? OUT_W'(-quo) : OUT_W'(quo);
            out_sb <= sb_q[QBITS-1];
        end else begin
            out_q  <= '0;
            out_sb <= '0;
        end
    end
endmodule

// File: rtl/hs_opt_flow_top.sv
// Streaming single-iteration Horn-Schunck flow, with u and v on alternate frames and one Q16.10 result per pixel.
// Latency is 34 cycles; there is no backpressure, so a pixel is accepted on every clock after reset.
module hs_opt_flow_top #(
    parameter int IMAGE_WIDTH  = hs_opt_flow_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = hs_opt_flow_pkg::IMAGE_HEIGHT,
    parameter int ALPHA2       = hs_opt_flow_pkg::ALPHA2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 io_frame_sync_in,
    input  logic [7:0]                           io_data_in1,
    input  logic [7:0]                           io_data_in2,
    output logic                                 io_frame_sync_out,
    output logic [hs_opt_flow_pkg::FP_WIDTH-1:0] io_data_out
);
    import hs_opt_flow_pkg::*;

    localparam int CW = (IMAGE_WIDTH  > 1) ? $clog2(IMAGE_WIDTH)  : 1;
    localparam int RW = (IMAGE_HEIGHT > 1) ? $clog2(IMAGE_HEIGHT) : 1;

    logic [CW-1:0] col_q, cur_col;
    logic [RW-1:0] row_q, cur_row;
    logic          first_q;
    comp_e         sel_q, cur_sel;

    pix_t line1 [IMAGE_WIDTH];
    pix_t line2 [IMAGE_WIDTH];
    pix_t a1_q, b1_q, c1_q, d1_q, a2_q, b2_q, c2_q, d2_q;

    logic  s1_vld, s2_vld, s3_vld;
    meta_t s1_meta, s2_meta;
    logic  s3_sync;
    grad_t gx_q, gy_q, gt_q;
    logic [DEN_W-1:0]        den_c, den_q;
    logic signed [NUM_W-1:0] num_c, num_q;
    logic signed [2*GRAD_W-1:0] gx_sq, gy_sq, g_prod;
    grad_t gsel;

    // The first sync after reset keeps u; every later sync flips the component.
    always_comb begin
        cur_col = io_frame_sync_in ? '0 : col_q;
        cur_row = io_frame_sync_in ? '0 : row_q;
        cur_sel = sel_q;
        if (io_frame_sync_in && !first_q) cur_sel = (sel_q == COMP_U) ? COMP_V : COMP_U;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q   <= '0;
            row_q   <= '0;
            sel_q   <= COMP_U;
            first_q <= 1'b1;
        end else begin
            sel_q <= cur_sel;
            if (io_frame_sync_in) first_q <= 1'b0;
            if (cur_col == CW'(IMAGE_WIDTH - 1)) begin
                col_q <= '0;
                row_q <= (cur_row == RW'(IMAGE_HEIGHT - 1)) ? '0 : cur_row + 1'b1;
            end else begin
                col_q <= cur_col + 1'b1;
                row_q <= cur_row;
            end
        end
    end

    // After this stage, d/b hold (r,c)/(r-1,c), and c/a hold the previous column of each.
    always_ff @(posedge clk) begin
        line1[cur_col] <= io_data_in1;
        line2[cur_col] <= io_data_in2;
        b1_q <= line1[cur_col];
        b2_q <= line2[cur_col];
        d1_q <= io_data_in1;
        d2_q <= io_data_in2;
        a1_q <= b1_q;
        a2_q <= b2_q;
        c1_q <= d1_q;
        c2_q <= d2_q;
    end

    always_ff @(posedge clk) begin
        gx_q  <= pdiff(b1_q, a1_q) + pdiff(d1_q, c1_q) + pdiff(b2_q, a2_q) + pdiff(d2_q, c2_q);
        gy_q  <= pdiff(c1_q, a1_q) + pdiff(d1_q, b1_q) + pdiff(c2_q, a2_q) + pdiff(d2_q, b2_q);
        gt_q  <= pdiff(a2_q, a1_q) + pdiff(b2_q, b1_q) + pdiff(c2_q, c1_q) + pdiff(d2_q, d1_q);
        den_q <= den_c;
        num_q <= num_c;
    end

    always_comb begin
        gx_sq  = gx_q * gx_q;
        gy_sq  = gy_q * gy_q;
        gsel   = (s2_meta.comp == COMP_U) ? gx_q : gy_q;
        g_prod = gsel * gt_q;
        den_c  = DEN_W'(16 * ALPHA2) + DEN_W'($unsigned(gx_sq)) + DEN_W'($unsigned(gy_sq));
        num_c  = s2_meta.bnd ? '0 : -(NUM_W'(g_prod) <<< FRAC_BITS);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_vld  <= 1'b0;
            s2_vld  <= 1'b0;
            s3_vld  <= 1'b0;
            s1_meta <= '0;
            s2_meta <= '0;
            s3_sync <= 1'b0;
        end else begin
            s1_vld  <= 1'b1;
            s2_vld  <= s1_vld;
            s3_vld  <= s2_vld;
            s1_meta <= '{sync: io_frame_sync_in, comp: cur_sel, bnd: (cur_row == '0) || (cur_col == '0)};
            s2_meta <= s1_meta;
            s3_sync <= s2_meta.sync;
        end
    end

    hs_pipe_divider #(
        .NUM_W (NUM_W),
        .DEN_W (DEN_W),
        .QBITS (DIV_QBITS),
        .OUT_W (FP_WIDTH),
        .SB_W  (1)
    ) u_div (
        .clk    (clk),
        .reset  (reset),
        .in_vld (s3_vld),
        .in_num (num_q),
        .in_den (den_q),
        .in_sb  (s3_sync),
        .out_q  (io_data_out),
        .out_sb (io_frame_sync_out)
    );
endmodule

// File: tb/tb_hs_opt_flow_top.sv
// Bench for hs_opt_flow_top on a reduced 16x8 image, using a scoreboard of per-pixel expected outputs.
// Frame patterns come from a table; resync and mid-stream reset are driven as hand-written sequences.
`timescale 1ns/1ps
module tb_hs_opt_flow_top;
    import hs_opt_flow_pkg::*;

    localparam int W  = 16;
    localparam int H  = 8;
    localparam int A2 = 1;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                sync_in = 1'b0;
    logic [7:0]          d1 = '0;
    logic [7:0]          d2 = '0;
    logic                sync_out;
    logic [FP_WIDTH-1:0] dout;

    hs_opt_flow_top #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .ALPHA2       (A2)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .io_frame_sync_in  (sync_in),
        .io_data_in1       (d1),
        .io_data_in2       (d2),
        .io_frame_sync_out (sync_out),
        .io_data_out       (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                  due;
        logic                sync;
        logic [FP_WIDTH-1:0] val;
    } exp_t;

    typedef struct {
        int pat;
        bit comp_v;
        int exp_int;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[11];
    int   n_vec = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   br = 0;
    int   bc = 0;
    int   m1[H][W];
    int   m2[H][W];

    // Outputs are sampled on the falling edge; with no result due, both must be idle.
    task automatic check_out();
        exp_t e;
        e.due = cyc;
        e.sync = 1'b0;
        e.val = '0;
        if (sb.size() > 0 && sb[0].due == cyc) e = sb.pop_front();
        n_vec++;
        if (dout !== e.val || sync_out !== e.sync) begin
            n_bad++;
            $display("FAIL out cyc=%0d: got data=%0d sync=%b, want data=%0d sync=%b",
                     cyc, $signed(dout), sync_out, $signed(e.val), e.sync);
        end
    endtask

    task automatic tick(input bit rst, input bit s, input logic [7:0] p1, input logic [7:0] p2,
                        input logic [FP_WIDTH-1:0] ev);
        @(negedge clk);
        cyc++;
        check_out();
        reset   = rst;
        sync_in = s;
        d1      = p1;
        d2      = p2;
        if (rst) sb.delete();
        else     sb.push_back('{cyc + LATENCY, s, ev});
    endtask

    function automatic int model(input int r, input int c, input bit v);
        int gx, gy, gt;
        longint num, den;
        gx = (m1[r-1][c] - m1[r-1][c-1]) + (m1[r][c] - m1[r][c-1])
           + (m2[r-1][c] - m2[r-1][c-1]) + (m2[r][c] - m2[r][c-1]);
        gy = (m1[r][c-1] - m1[r-1][c-1]) + (m1[r][c] - m1[r-1][c])
           + (m2[r][c-1] - m2[r-1][c-1]) + (m2[r][c] - m2[r-1][c]);
        gt = (m2[r-1][c-1] - m1[r-1][c-1]) + (m2[r-1][c] - m1[r-1][c])
           + (m2[r][c-1] - m1[r][c-1]) + (m2[r][c] - m1[r][c]);
        den = longint'(16 * A2 + gx * gx + gy * gy);
        num = -(longint'(v ? gy : gx) * longint'(gt)) * 1024;
        return int'(num / den);
    endfunction

    task automatic drive_pixel(input int pat, input bit s, input bit comp_v, input int exp_int);
        logic [7:0] p1, p2;
        int ev;
        if (s) begin
            br = 0;
            bc = 0;
        end
        case (pat)
            0:       begin p1 = 8'd100;       p2 = 8'd100;          end
            1:       begin p1 = 8'd0;         p2 = 8'd8;            end
            2:       begin p1 = 8'(bc);       p2 = 8'(bc);          end
            3:       begin p1 = 8'(bc);       p2 = 8'(bc + 1);      end
            4:       begin p1 = 8'(2 * br);   p2 = 8'(2 * br + 3);  end
            5:       begin p1 = 8'(bc + 1);   p2 = 8'(bc);          end
            default: begin p1 = 8'($urandom_range(0, 255)); p2 = 8'($urandom_range(0, 255)); end
        endcase
        m1[br][bc] = int'(p1);
        m2[br][bc] = int'(p2);
        if (br == 0 || bc == 0) ev = 0;
        else if (pat == 6)      ev = model(br, bc, comp_v);
        else                    ev = exp_int;
        tick(1'b0, s, p1, p2, FP_WIDTH'(ev));
        if (bc == W - 1) begin
            bc = 0;
            br = (br == H - 1) ? 0 : br + 1;
        end else begin
            bc++;
        end
    endtask

    task automatic run_frame(input int pat, input bit comp_v, input int exp_int, input int n, input bit do_sync);
        for (int k = 0; k < n; k++) drive_pixel(pat, do_sync && (k == 0), comp_v, exp_int);
    endtask

    initial begin
        // pattern, component (1 = v), expected interior result
        tbl[0]  = '{1, 1'b0, 0};
        tbl[1]  = '{0, 1'b1, 0};
        tbl[2]  = '{3, 1'b0, -512};
        tbl[3]  = '{3, 1'b1, 0};
        tbl[4]  = '{3, 1'b0, -512};
        tbl[5]  = '{2, 1'b1, 0};
        tbl[6]  = '{4, 1'b0, 0};
        tbl[7]  = '{4, 1'b1, -1228};
        tbl[8]  = '{5, 1'b0, 512};
        tbl[9]  = '{6, 1'b1, 0};
        tbl[10] = '{6, 1'b0, 0};

        repeat (5) tick(1'b1, 1'b0, 8'd0, 8'd0, '0);

        for (int i = 0; i < 11; i++) run_frame(tbl[i].pat, tbl[i].comp_v, tbl[i].exp_int, W * H, 1'b1);

        // A v frame is resynchronised part-way through; the restarted frame is u.
        run_frame(3, 1'b1, 0, 40, 1'b1);
        run_frame(3, 1'b0, -512, W * H, 1'b1);

        // A reset mid-frame discards in-flight results, and the next frame starts from u again.
        run_frame(3, 1'b1, 0, 20, 1'b1);
        repeat (3) tick(1'b1, 1'b0, 8'd0, 8'd0, '0);
        run_frame(3, 1'b0, -512, W * H, 1'b1);
        run_frame(3, 1'b0, -512, LATENCY + 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
